dram_traffic_gen: RTL and testbench

- Parametrised DRAM traffic generator and checker. It sits between the PLL-clocked core and dram_control, on the same valid/ready/addr/wmask/wdata/rdata request port.
- On start it writes NUM_WORDS words of a selectable pattern over an address range, then reads them back and compares each word.
- Reports done, pass/fail, a saturating error count and the first failing address.
- Successor to the fixed-pattern, single-address write/read alternator.

---
 rtl/dram_traffic_gen_if.sv | 16 +
 rtl/dram_traffic_gen.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dram_traffic_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_traffic_gen_if.sv
// Request port between a traffic source and dram_control.
// Reads complete in the handshake cycle: rdata is valid while valid && ready.
interface dram_traffic_gen_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, addr, wmask, wdata, input ready, rdata);
    modport slave  (input valid, addr, wmask, wdata, output ready, rdata);
endinterface

// File: rtl/dram_traffic_gen.sv
// DRAM traffic generator/checker: writes NUM_WORDS pattern words, reads them back, and counts mismatches.
// Define TRAFFIC_LOOP_EN to repeat runs continuously until stopped by a second start.
module dram_traffic_gen #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ADDR_STEP = 16,
    parameter int unsigned NUM_WORDS = 256,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [15:0]       loop_count,
    dram_traffic_gen_if.master req
);

    localparam int unsigned    LANES     = DATA_W / 32;
    localparam int unsigned    IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]    SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0]    LFSR_TAPS = 32'h8020_0003;
    localparam logic [127:0]   FIXED_PAT = 128'h0123456789abcdef_deadbeef_abad1dea;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Galois step for x^32+x^22+x^2+x+1, right-shifting form
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < int'(LANES); k++) t = lfsr_step(t);
        return t;
    endfunction

    // Word pattern: s is the LFSR state for lane 0, c the counter value for lane 0
    function automatic logic [DATA_W-1:0] gen_pat(input logic [1:0] m, input logic [31:0] s,
                                                  input logic [31:0] c);
        logic [DATA_W-1:0] p;
        logic [31:0]       t;
        p = '0;
        t = s;
        for (int k = 0; k < int'(LANES); k++) begin
            case (m)
                2'd1:    p[k*32 +: 32] = c + 32'(k);
                2'd2: begin
                    p[k*32 +: 32] = t;
                    t = lfsr_step(t);
                end
                default: p[k*32 +: 32] = FIXED_PAT[(k % 4)*32 +: 32];
            endcase
        end
        return p;
    endfunction

    logic [1:0]        state, state_n;
    logic              busy_n, done_n, pass_n;
    logic [15:0]       err_n;
    logic [ADDR_W-1:0] fea_n;
    logic              valid_n, wmask_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [31:0]       lfsr, lfsr_n, lfsr_base, lfsr_base_n;
    logic [31:0]       cnt, cnt_n, cnt_base, cnt_base_n;
    logic [1:0]        mode_r, mode_n;
    logic [ADDR_W-1:0] base_r, base_n;
    logic [DATA_W-1:0] exp_pat, exp_n;

    logic              hs;
    logic              stop_hit;
    logic [31:0]       adv_lfsr, adv_cnt;
    logic [DATA_W-1:0] adv_pat, start_pat, reload_pat;

`ifdef TRAFFIC_LOOP_EN
    logic [15:0]       loop_r, loop_n;
    logic              stop_r, stop_n;
    logic [31:0]       loop_cnt;
    logic [DATA_W-1:0] loop_pat;

    assign loop_count = loop_r;
    assign stop_hit   = stop_r | (start & busy);
    assign loop_cnt   = 32'(loop_r + 16'd1);
    assign loop_pat   = gen_pat(mode_r, lfsr, loop_cnt);
`else
    assign loop_count = 16'd0;
    assign stop_hit   = 1'b0;
`endif

    assign hs         = req.valid && req.ready;
    assign adv_lfsr   = lfsr_adv(lfsr);
    assign adv_cnt    = cnt + 32'(LANES);
    assign adv_pat    = gen_pat(mode_r, adv_lfsr, adv_cnt);
    assign start_pat  = gen_pat(mode, SEED_EFF, 32'd0);
    assign reload_pat = gen_pat(mode_r, lfsr_base, cnt_base);

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        busy_n      = busy;
        done_n      = 1'b0;
        pass_n      = pass;
        err_n       = err_count;
        fea_n       = first_err_addr;
        valid_n     = req.valid;
        wmask_n     = req.wmask;
        addr_n      = req.addr;
        wdata_n     = req.wdata;
        idx_n       = idx;
        lfsr_n      = lfsr;
        lfsr_base_n = lfsr_base;
        cnt_n       = cnt;
        cnt_base_n  = cnt_base;
        mode_n      = mode_r;
        base_n      = base_r;
        exp_n       = exp_pat;
`ifdef TRAFFIC_LOOP_EN
        loop_n      = loop_r;
        stop_n      = stop_r | (start & busy);
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_WRITE;
                    busy_n      = 1'b1;
                    pass_n      = 1'b0;
                    err_n       = 16'd0;
                    fea_n       = '0;
                    mode_n      = mode;
                    base_n      = base_addr;
                    idx_n       = '0;
                    lfsr_n      = SEED_EFF;
                    lfsr_base_n = SEED_EFF;
                    cnt_n       = 32'd0;
                    cnt_base_n  = 32'd0;
                    valid_n     = 1'b1;
                    wmask_n     = 1'b1;
                    addr_n      = base_addr;
                    exp_n       = start_pat;
                    wdata_n     = start_pat;
`ifdef TRAFFIC_LOOP_EN
                    loop_n      = 16'd0;
`endif
                end
            end
            S_WRITE: begin
                if (hs) begin
                    if (stop_hit) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        valid_n = 1'b0;
                        wmask_n = 1'b0;
                        wdata_n = '0;
                    end else if (idx == LAST_IDX) begin
                        // one idle cycle between phases; rewind the pattern for readback
                        state_n = S_READ;
                        valid_n = 1'b0;
                        wmask_n = 1'b0;
                        wdata_n = '0;
                        idx_n   = '0;
                        lfsr_n  = lfsr_base;
                        cnt_n   = cnt_base;
                        addr_n  = base_r;
                        exp_n   = reload_pat;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        lfsr_n  = adv_lfsr;
                        cnt_n   = adv_cnt;
                        addr_n  = req.addr + ADDR_W'(ADDR_STEP);
                        exp_n   = adv_pat;
                        wdata_n = adv_pat;
                    end
                end
            end
            S_READ: begin
                if (!req.valid) begin
                    if (stop_hit) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        valid_n = 1'b1;
                    end
                end else if (hs) begin
                    if (req.rdata != exp_pat) begin
                        if (err_count != 16'hFFFF) err_n = err_count + 16'd1;
                        if (err_count == 16'd0) fea_n = req.addr;
                    end
                    if (stop_hit) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        valid_n = 1'b0;
                    end else if (idx == LAST_IDX) begin
                        state_n = S_FIN;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 16'd0);
                    end else begin
                        idx_n  = idx + IDX_W'(1);
                        lfsr_n = adv_lfsr;
                        cnt_n  = adv_cnt;
                        addr_n = req.addr + ADDR_W'(ADDR_STEP);
                        exp_n  = adv_pat;
                    end
                end
            end
            default: begin
`ifdef TRAFFIC_LOOP_EN
                if (stop_hit) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    // next loop continues the LFSR and offsets the counter by the loop number
                    state_n     = S_WRITE;
                    loop_n      = loop_r + 16'd1;
                    idx_n       = '0;
                    lfsr_base_n = lfsr;
                    cnt_n       = loop_cnt;
                    cnt_base_n  = loop_cnt;
                    addr_n      = base_r;
                    valid_n     = 1'b1;
                    wmask_n     = 1'b1;
                    exp_n       = loop_pat;
                    wdata_n     = loop_pat;
                end
`else
                state_n = S_IDLE;
                busy_n  = 1'b0;
`endif
            end
        endcase
`ifdef TRAFFIC_LOOP_EN
        if (state_n == S_IDLE) stop_n = 1'b0;
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_err_addr <= '0;
            req.valid      <= 1'b0;
            req.wmask      <= 1'b0;
            req.addr       <= '0;
            req.wdata      <= '0;
            idx            <= '0;
            lfsr           <= 32'd0;
            lfsr_base      <= 32'd0;
            cnt            <= 32'd0;
            cnt_base       <= 32'd0;
            mode_r         <= 2'd0;
            base_r         <= '0;
            exp_pat        <= '0;
`ifdef TRAFFIC_LOOP_EN
            loop_r         <= 16'd0;
            stop_r         <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_err_addr <= fea_n;
            req.valid      <= valid_n;
            req.wmask      <= wmask_n;
            req.addr       <= addr_n;
            req.wdata      <= wdata_n;
            idx            <= idx_n;
            lfsr           <= lfsr_n;
            lfsr_base      <= lfsr_base_n;
            cnt            <= cnt_n;
            cnt_base       <= cnt_base_n;
            mode_r         <= mode_n;
            base_r         <= base_n;
            exp_pat        <= exp_n;
`ifdef TRAFFIC_LOOP_EN
            loop_r         <= loop_n;
            stop_r         <= stop_n;
`endif
        end
    end

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Bench for dram_traffic_gen: memory-backed slave with optional stalls and read bit flips,
// a table of directed runs, and a mid-run reset sequence.
module tb_dram_traffic_gen;

    localparam int unsigned DW   = 128;
    localparam int unsigned AW   = 32;
    localparam int unsigned NW   = 4;
    localparam int unsigned STEP = 16;
    localparam logic [127:0] FIXED = 128'h0123456789abcdef_deadbeef_abad1dea;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic        busy, done, pass;
    logic [15:0] err_count, loop_count;
    logic [31:0] first_err_addr;

    always #5 clk = ~clk;

    dram_traffic_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dram_traffic_gen #(
        .DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(STEP), .NUM_WORDS(NW), .SEED(32'hACE1_2468)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .base_addr(base_addr),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .loop_count(loop_count), .req(bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Slave: fixed stall per request, stores writes, returns stored words with optional bit-5 flip
    typedef struct {
        logic [31:0]  addr;
        logic         wmask;
        logic [127:0] wdata;
    } txn_t;

    txn_t         lq[$];
    logic [127:0] mem [4];
    int           stall_cfg = 0;
    logic [3:0]   flip = 4'd0;
    logic [31:0]  base_cur = 32'd0;
    int           st_cnt = 0;
    int           stab_cnt = 0;
    int           stab_bad = 0;
    logic [160:0] hold = '0;
    int           done_cnt = 0;

    always @(negedge clk) begin : slave
        logic [1:0] wi;
        txn_t       t;
        wi = 2'((bus.addr - base_cur) >> 4);
        if (bus.valid === 1'b1) begin
            if (st_cnt > 0) begin
                stab_cnt++;
                if ({bus.addr, bus.wmask, bus.wdata} !== hold) stab_bad++;
            end else begin
                hold = {bus.addr, bus.wmask, bus.wdata};
            end
            if (st_cnt < stall_cfg) begin
                bus.ready = 1'b0;
                st_cnt++;
            end else begin
                bus.ready = 1'b1;
                st_cnt    = 0;
                t.addr  = bus.addr;
                t.wmask = bus.wmask;
                t.wdata = bus.wdata;
                lq.push_back(t);
                if (bus.wmask) begin
                    mem[wi]   = bus.wdata;
                    bus.rdata = '0;
                end else begin
                    bus.rdata = mem[wi] ^ (flip[wi] ? 128'h20 : 128'h0);
                end
            end
        end else begin
            bus.ready = (stall_cfg == 0);
            bus.rdata = '0;
            st_cnt    = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [1:0]   mode;
        int           stall;
        logic [3:0]   flip;
        logic [31:0]  base;
        bit           restart;
        logic [15:0]  exp_err;
        logic [31:0]  exp_first;
        logic         exp_pass;
        int           exp_lat;
        logic [127:0] exp_w0;
        logic [31:0]  exp_w1l0;
        bit           chk_w2;
        logic [127:0] exp_w2;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int vi, input vec_t v);
        int  cyc;
        int  d0;
        bit  seq_ok;
        logic [31:0] ea;
        string p;
        p = $sformatf("v%0d_", vi);
        lq.delete();
        stall_cfg = v.stall;
        flip      = v.flip;
        base_cur  = v.base;
        stab_cnt  = 0;
        stab_bad  = 0;
        d0        = done_cnt;
        @(negedge clk);
        start = 1'b1; mode = v.mode; base_addr = v.base;
        @(negedge clk);
        start = 1'b0; base_addr = 32'h0;
        chk({p, "busy_run"}, 128'(busy), 128'(1'b1));
        chk({p, "first_valid"}, 128'({bus.valid, bus.wmask, bus.addr}), 128'({2'b11, v.base}));
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            if (v.restart && cyc == 3) begin
                start = 1'b1; base_addr = 32'hDEAD_0000;
            end else begin
                start = 1'b0; base_addr = 32'h0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({p, "done_seen"}, 128'(done), 128'(1'b1));
        if (v.exp_lat != 0) chk({p, "latency"}, 128'(cyc + 1), 128'(v.exp_lat));
        chk({p, "pass"}, 128'(pass), 128'(v.exp_pass));
        chk({p, "err_count"}, 128'(err_count), 128'(v.exp_err));
        chk({p, "first_err_addr"}, 128'(first_err_addr), 128'(v.exp_first));
        chk({p, "txn_count"}, 128'(lq.size()), 128'(2 * NW));
        if (lq.size() == 2 * NW) begin
            seq_ok = 1'b1;
            for (int j = 0; j < int'(2 * NW); j++) begin
                ea = v.base + 32'((j % int'(NW)) * int'(STEP));
                if (lq[j].addr !== ea || lq[j].wmask !== (j < int'(NW))) begin
                    if (seq_ok) $display("FAIL %saddr_seq: txn %0d got addr %0h wmask %0b, expected addr %0h wmask %0b",
                                         p, j, lq[j].addr, lq[j].wmask, ea, (j < int'(NW)));
                    seq_ok = 1'b0;
                end
            end
            n_total++;
            if (seq_ok) n_pass++;
            chk({p, "wdata_w0"}, lq[0].wdata, v.exp_w0);
            chk({p, "wdata_w1_lane0"}, 128'(lq[1].wdata[31:0]), 128'(v.exp_w1l0));
            if (v.chk_w2) chk({p, "wdata_w2"}, lq[2].wdata, v.exp_w2);
        end
        if (v.stall > 0) begin
            chk({p, "stall_samples"}, 128'(stab_cnt), 128'(2 * NW * v.stall));
            chk({p, "stall_stable"}, 128'(stab_bad), 128'(0));
        end
        @(negedge clk);
        chk({p, "idle_after"}, 128'({busy, done, bus.valid}), 128'(3'b000));
        chk({p, "pass_held"}, 128'(pass), 128'(v.exp_pass));
        chk({p, "done_pulses"}, 128'(done_cnt - d0), 128'(1));
    endtask

    initial begin
        int cyc;
        int d0;
        logic [127:0] lfsr_w0;
        logic [127:0] cnt_w0;
        logic [127:0] cnt_w2;
        lfsr_w0 = 128'h159C248D_2B38491A_56709234_ACE12468;
        cnt_w0  = 128'h00000003_00000002_00000001_00000000;
        cnt_w2  = 128'h0000000b_0000000a_00000009_00000008;
        rstn = 1'b0; start = 1'b0; mode = 2'd0; base_addr = 32'h0;

        vecs[0] = '{mode: 2'd0, stall: 0, flip: 4'b0000, base: 32'h100, restart: 1'b0,
                    exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1, exp_lat: 10,
                    exp_w0: FIXED, exp_w1l0: 32'habad1dea, chk_w2: 1'b1, exp_w2: FIXED};
        vecs[1] = '{mode: 2'd0, stall: 3, flip: 4'b0000, base: 32'h100, restart: 1'b0,
                    exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1, exp_lat: 34,
                    exp_w0: FIXED, exp_w1l0: 32'habad1dea, chk_w2: 1'b1, exp_w2: FIXED};
        vecs[2] = '{mode: 2'd1, stall: 0, flip: 4'b0000, base: 32'h100, restart: 1'b0,
                    exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1, exp_lat: 10,
                    exp_w0: cnt_w0, exp_w1l0: 32'h4, chk_w2: 1'b1, exp_w2: cnt_w2};
        vecs[3] = '{mode: 2'd2, stall: 0, flip: 4'b1010, base: 32'h100, restart: 1'b0,
                    exp_err: 16'd2, exp_first: 32'h110, exp_pass: 1'b0, exp_lat: 10,
                    exp_w0: lfsr_w0, exp_w1l0: 32'h8AEE1245, chk_w2: 1'b0, exp_w2: '0};
        vecs[4] = '{mode: 2'd3, stall: 0, flip: 4'b0000, base: 32'h200, restart: 1'b1,
                    exp_err: 16'd0, exp_first: 32'h0, exp_pass: 1'b1, exp_lat: 10,
                    exp_w0: FIXED, exp_w1l0: 32'habad1dea, chk_w2: 1'b1, exp_w2: FIXED};
        vecs[5] = '{mode: 2'd1, stall: 1, flip: 4'b0001, base: 32'hFFFF_FFF0, restart: 1'b0,
                    exp_err: 16'd1, exp_first: 32'hFFFF_FFF0, exp_pass: 1'b0, exp_lat: 18,
                    exp_w0: cnt_w0, exp_w1l0: 32'h4, chk_w2: 1'b1, exp_w2: cnt_w2};

        #2;
        chk("rst_ctrl", 128'({busy, done, pass, bus.valid, bus.wmask}), 128'(5'b0));
        chk("rst_counts", 128'({err_count, loop_count, first_err_addr}), 128'(0));
        chk("rst_bus", 128'({bus.addr, bus.wdata[95:0]}), 128'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        for (int vi = 0; vi < 6; vi++) run_vec(vi, vecs[vi]);

        // Reset while the third read is on the bus
        lq.delete();
        stall_cfg = 0; flip = 4'd0; base_cur = 32'h100;
        @(negedge clk);
        start = 1'b1; mode = 2'd0; base_addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        d0  = done_cnt;
        cyc = 0;
        while (!(bus.valid === 1'b1 && bus.wmask === 1'b0 && bus.addr === 32'h120) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached", 128'({bus.valid, bus.wmask, bus.addr}), 128'({2'b10, 32'h120}));
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(bus.valid), 128'(1'b0));
        chk("rst_mid_ctrl", 128'({busy, done, pass, bus.wmask}), 128'(4'b0));
        chk("rst_mid_regs", 128'({err_count, first_err_addr, bus.addr}), 128'(0));
        chk("rst_mid_wdata", bus.wdata, 128'(0));
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 128'(done_cnt - d0), 128'(0));
        chk("rst_mid_still_idle", 128'({busy, bus.valid}), 128'(2'b00));
        rstn = 1'b1;
        run_vec(6, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
